// File: rtl/lcd_read.sv
// lcd_read: read-side controller for an HD44780-compatible character LCD.
// Drives RS/RW/E with read-cycle timing and captures the byte the panel returns.
// Optional feature macro: LCD_READ_POLL_EN. When it is defined, a busy-flag read
// (RS=0) that sees DB7=1 repeats automatically. oFlag then pulses only once the
// panel reports ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | bus released (RW=0, E=0), waiting for iCe
// SETUP   | RS/RW stable, E low, address setup time
// EN_HIGH | E high, panel drives DB; capture on the last cycle
// EN_LOW  | E low, RS/RW still held for hold time / cycle time
// DONE    | one-cycle oFlag, then release the bus
module lcd_read #(
    parameter int unsigned SETUP_CYC   = 3,
    parameter int unsigned EN_HIGH_CYC = 25,
    parameter int unsigned EN_LOW_CYC  = 25
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iCe,
    input  logic       iRS,
    input  logic [7:0] iDato,
    output logic       oEnable,
    output logic       oRS,
    output logic       oRW,
    output logic [7:0] oDato,
    output logic       oBusy,
    output logic       oFlag
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HIGH,
        EN_LOW,
        DONE
    } state_t;

    localparam logic [15:0] SETUP_LD   = 16'(SETUP_CYC);
    localparam logic [15:0] EN_HIGH_LD = 16'(EN_HIGH_CYC);
    localparam logic [15:0] EN_LOW_LD  = 16'(EN_LOW_CYC);

    state_t      state;
    logic [15:0] cnt;
    logic        lastCyc;
    logic        repoll;

    // A timed state ends on the cycle its down-counter would reach zero.
    assign lastCyc = (cnt == 16'd1);

`ifdef LCD_READ_POLL_EN
    // oBusy was just updated at the end of EN_HIGH, so it holds this read's DB7.
    // oRS is the RS value latched when the request was accepted.
    assign repoll = ~oRS & oBusy;
`else
    assign repoll = 1'b0;
`endif

    // Read-cycle sequencer. All panel-facing outputs are registered here.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            oEnable <= 1'b0;
            oRS     <= 1'b0;
            oRW     <= 1'b0;
            oDato   <= 8'h00;
            oBusy   <= 1'b1;
            oFlag   <= 1'b0;
        end else begin
            oFlag <= 1'b0;
            case (state)
                IDLE: begin
                    oEnable <= 1'b0;
                    if (iCe) begin
                        oRS   <= iRS;
                        oRW   <= 1'b1;
                        cnt   <= SETUP_LD;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (lastCyc) begin
                        oEnable <= 1'b1;
                        cnt     <= EN_HIGH_LD;
                        state   <= EN_HIGH;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                EN_HIGH: begin
                    if (lastCyc) begin
                        // Sample DB while E is still high; the panel may release it after the fall.
                        oEnable <= 1'b0;
                        oDato   <= iDato;
                        if (!oRS) begin
                            oBusy <= iDato[7];
                        end
                        cnt   <= EN_LOW_LD;
                        state <= EN_LOW;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                EN_LOW: begin
                    if (lastCyc) begin
                        if (repoll) begin
                            cnt   <= SETUP_LD;
                            state <= SETUP;
                        end else begin
                            oFlag <= 1'b1;
                            cnt   <= 16'd0;
                            state <= DONE;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DONE: begin
                    oRW   <= 1'b0;
                    oRS   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    oEnable <= 1'b0;
                    oRW     <= 1'b0;
                    cnt     <= 16'd0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_read.sv
// tb_lcd_read: directed bench for lcd_read with default timing (S=3, H=25, L=25).
// A scoreboard queue holds the expected {oDato, oBusy} for each read. A monitor
// pops one entry and compares it on every oFlag pulse.
module tb_lcd_read;

    localparam int S = 3;
    localparam int H = 25;
    localparam int L = 25;

    logic       iClk = 1'b0;
    logic       iReset;
    logic       iCe;
    logic       iRS;
    logic [7:0] iDato;
    logic       oEnable;
    logic       oRS;
    logic       oRW;
    logic [7:0] oDato;
    logic       oBusy;
    logic       oFlag;

    int passed = 0;
    int total  = 0;
    int flagCount = 0;
    logic [8:0] expQ[$];
    logic busyModel;

    lcd_read dut (
        .iClk   (iClk),
        .iReset (iReset),
        .iCe    (iCe),
        .iRS    (iRS),
        .iDato  (iDato),
        .oEnable(oEnable),
        .oRS    (oRS),
        .oRW    (oRW),
        .oDato  (oDato),
        .oBusy  (oBusy),
        .oFlag  (oFlag)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every completion pops one expected entry.
    initial begin
        forever begin
            @(negedge iClk);
            if (oFlag) begin
                flagCount++;
                if (expQ.size() == 0) begin
                    check("unexpected_flag", 1, 0);
                end else begin
                    logic [8:0] e;
                    e = expQ.pop_front();
                    check("sb_dato", int'(oDato), int'(e[8:1]));
                    check("sb_busy", int'(oBusy), int'(e[0]));
                end
            end
        end
    end

    // One read transaction with timing checks relative to the acceptance edge.
    // k counts negedges after acceptance edge N (k=0 is the first one).
    task automatic runRead(input string tag, input logic rs, input logic [7:0] data,
                           input bit extraCe);
        int eFirst, eCount, flagCyc, rwLow, flags0;
        logic [8:0] e;
        eFirst = -1; eCount = 0; flagCyc = -1; rwLow = -1;
        flags0 = flagCount;
        e[8:1] = data;
        e[0]   = rs ? busyModel : data[7];
        busyModel = e[0];
        expQ.push_back(e);
        @(negedge iClk);
        iRS = rs;
        iCe = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge iClk);
            if (k == 0) begin
                iCe = 1'b0;
                iRS = ~rs;
                check({tag, "_rw_at_accept"}, int'(oRW), 1);
            end
            if (extraCe && k == 10) iCe = 1'b1;
            if (extraCe && k == 11) iCe = 1'b0;
            if (k == 20) check({tag, "_rs_held"}, int'(oRS), int'(rs));
            if (oEnable) begin
                if (eFirst < 0) eFirst = k;
                eCount++;
                iDato = data;
            end else begin
                iDato = 8'hEE;
            end
            if (oFlag && flagCyc < 0) flagCyc = k;
            if (!oRW && rwLow < 0) rwLow = k;
        end
        check({tag, "_e_start"}, eFirst, S);
        check({tag, "_e_width"}, eCount, H);
        check({tag, "_flag_cycle"}, flagCyc, S + H + L);
        check({tag, "_rw_release"}, rwLow, S + H + L + 1);
        check({tag, "_flag_count"}, flagCount - flags0, 1);
        check({tag, "_idle_e"}, int'(oEnable), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        iReset = 1'b1; iCe = 1'b0; iRS = 1'b0; iDato = 8'hEE;
        busyModel = 1'b1;
        repeat (2) @(negedge iClk);
        check("rst_enable", int'(oEnable), 0);
        check("rst_rw", int'(oRW), 0);
        check("rst_rs", int'(oRS), 0);
        check("rst_dato", int'(oDato), 8'h00);
        check("rst_busy", int'(oBusy), 1);
        check("rst_flag", int'(oFlag), 0);
        iReset = 1'b0;
        repeat (3) @(negedge iClk);

        runRead("data", 1'b1, 8'hA5, 1'b0);
        runRead("busy", 1'b0, 8'h0C, 1'b0);
        runRead("ignored", 1'b1, 8'h3C, 1'b1);

        // Reset during EN_HIGH: E and RW drop at that edge, no completion.
        begin
            int flags0;
            flags0 = flagCount;
            @(negedge iClk);
            iRS = 1'b1; iCe = 1'b1;
            @(negedge iClk);
            iCe = 1'b0;
            repeat (10) @(negedge iClk);
            check("midrst_e_before", int'(oEnable), 1);
            iReset = 1'b1;
            @(negedge iClk);
            iReset = 1'b0;
            check("midrst_enable", int'(oEnable), 0);
            check("midrst_rw", int'(oRW), 0);
            check("midrst_busy", int'(oBusy), 1);
            busyModel = 1'b1;
            repeat (60) @(negedge iClk);
            check("midrst_no_flag", flagCount - flags0, 0);
        end
        runRead("after_rst", 1'b0, 8'h4E, 1'b0);

`ifdef LCD_READ_POLL_EN
        // Busy twice, then ready: three E pulses, one completion.
        begin
            int pulses, flags0, k;
            logic prevE;
            logic [8:0] e;
            pulses = 0; prevE = 1'b0; flags0 = flagCount;
            e = {8'h03, 1'b0};
            expQ.push_back(e);
            busyModel = 1'b0;
            @(negedge iClk);
            iRS = 1'b0; iCe = 1'b1;
            k = 0;
            while (k < 300 && flagCount == flags0) begin
                @(negedge iClk);
                iCe = 1'b0;
                if (oEnable && !prevE) pulses++;
                prevE = oEnable;
                iDato = oEnable ? ((pulses < 3) ? 8'h80 : 8'h03) : 8'hEE;
                k++;
            end
            repeat (5) @(negedge iClk);
            check("poll_pulses", pulses, 3);
            check("poll_flags", flagCount - flags0, 1);
            check("poll_busy", int'(oBusy), 0);
            check("poll_dato", int'(oDato), 8'h03);
        end
`else
        // Without polling, a busy capture still completes once and reports busy.
        runRead("busy_hi", 1'b0, 8'h8F, 1'b0);
`endif

        repeat (3) @(negedge iClk);
        check("queue_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
